// File: rtl/seq_cu_pkg.sv
// rtl/seq_cu_pkg.sv - shared types and encodings for the multi-cycle sequencer
package seq_cu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_INDIRECT,
    ST_MEM_RD,
    ST_EXEC,
    ST_INC,
    ST_MEM_WR,
    ST_BRANCH,
    ST_REG_EXEC,
    ST_DONE,
    ST_HALT
  } state_e;

  localparam logic [OP_W-1:0] OP_AND    = 3'd0;
  localparam logic [OP_W-1:0] OP_ADD    = 3'd1;
  localparam logic [OP_W-1:0] OP_LDA    = 3'd2;
  localparam logic [OP_W-1:0] OP_STA    = 3'd3;
  localparam logic [OP_W-1:0] OP_BUN    = 3'd4;
  localparam logic [OP_W-1:0] OP_BSA    = 3'd5;
  localparam logic [OP_W-1:0] OP_ISZ    = 3'd6;
  localparam logic [OP_W-1:0] OP_IO_REG = 3'd7;

  localparam logic [1:0] WSEL_AC = 2'd0;
  localparam logic [1:0] WSEL_PC = 2'd1;
  localparam logic [1:0] WSEL_DR = 2'd2;

  localparam logic [1:0] ALU_AND = 2'd0;
  localparam logic [1:0] ALU_ADD = 2'd1;
  localparam logic [1:0] ALU_LDA = 2'd2;

  localparam int REG_SPA = 4;
  localparam int REG_SNA = 3;
  localparam int REG_SZA = 2;
  localparam int REG_SZE = 1;
  localparam int REG_HLT = 0;

  // Opcode 7 never reaches dispatch; it is resolved in DECODE.
  function automatic state_e dispatch_state(input logic [OP_W-1:0] op);
    case (op)
      OP_AND, OP_ADD, OP_LDA, OP_ISZ: dispatch_state = ST_MEM_RD;
      OP_STA, OP_BSA:                 dispatch_state = ST_MEM_WR;
      OP_BUN:                         dispatch_state = ST_BRANCH;
      default:                        dispatch_state = ST_HALT;
    endcase
  endfunction

  function automatic logic is_mem_state(input state_e st);
    is_mem_state = (st == ST_FETCH) || (st == ST_INDIRECT) ||
                   (st == ST_MEM_RD) || (st == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/seq_cu_watchdog.sv
// rtl/seq_cu_watchdog.sv - memory acknowledge timeout counter
module seq_cu_watchdog #(
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_WIDTH    = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic count_en_i,
  output logic timeout_o
);

  localparam logic [TO_WIDTH-1:0] LIMIT =
      (MEM_TIMEOUT > 0) ? TO_WIDTH'(MEM_TIMEOUT - 1) : '0;
  localparam logic ENABLED = (MEM_TIMEOUT > 0);

  logic [TO_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_en_i already excludes ack cycles, so a late ack always wins.
  assign timeout_o = ENABLED && count_en_i && (count_q == LIMIT);

endmodule

// File: rtl/seq_control_unit.sv
// rtl/seq_control_unit.sv - multi-cycle sequencer driving datapath and memory enables
module seq_control_unit
  import seq_cu_pkg::*;
#(
  parameter int AWIDTH      = 12,
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_WIDTH    = 8,
  localparam int DWIDTH     = AWIDTH + 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_run,
  input  logic [DWIDTH-1:0] i_ir,
  input  logic              i_mem_ack,
  input  logic              i_ac_zero,
  input  logic              i_ac_neg,
  input  logic              i_e,
  input  logic              i_dr_zero,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic              o_addr_sel,
  output logic [1:0]        o_wdata_sel,
  output logic              o_ir_load,
  output logic              o_pc_inc,
  output logic              o_pc_load_ar,
  output logic              o_ar_load_ir,
  output logic              o_ar_load_dr,
  output logic              o_ar_inc,
  output logic              o_dr_load,
  output logic              o_dr_inc,
  output logic [1:0]        o_alu_op,
  output logic              o_alu_en,
  output logic [11:0]       o_reg_op,
  output logic              o_reg_en,
  output logic              o_busy,
  output logic              o_halted,
  output logic              o_err
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] opcode_q, opcode_d;
  logic            err_q, err_d;
  logic            timeout;

  logic            ir_ind;
  logic [OP_W-1:0] ir_op;
  logic            skip;

  assign ir_ind = i_ir[DWIDTH-1];
  assign ir_op  = i_ir[DWIDTH-2:AWIDTH];
  assign skip   = (i_ir[REG_SPA] & ~i_ac_neg) | (i_ir[REG_SNA] & i_ac_neg) |
                  (i_ir[REG_SZA] & i_ac_zero) | (i_ir[REG_SZE] & ~i_e);

  seq_cu_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_WIDTH   (TO_WIDTH)
  ) u_watchdog (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .clear_i   (state_d != state_q),
    .count_en_i(is_mem_state(state_q) && !i_mem_ack),
    .timeout_o (timeout)
  );

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    err_d        = err_q;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_addr_sel   = 1'b0;
    o_wdata_sel  = WSEL_AC;
    o_ir_load    = 1'b0;
    o_pc_inc     = 1'b0;
    o_pc_load_ar = 1'b0;
    o_ar_load_ir = 1'b0;
    o_ar_load_dr = 1'b0;
    o_ar_inc     = 1'b0;
    o_dr_load    = 1'b0;
    o_dr_inc     = 1'b0;
    o_alu_op     = ALU_AND;
    o_alu_en     = 1'b0;
    o_reg_op     = '0;
    o_reg_en     = 1'b0;
    o_busy       = 1'b1;
    o_halted     = 1'b0;
    o_err        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        o_mem_req = 1'b1;
        if (i_mem_ack) begin
          o_ir_load = 1'b1;
          o_pc_inc  = 1'b1;
          state_d   = ST_DECODE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_DECODE: begin
        o_ar_load_ir = 1'b1;
        opcode_d     = ir_op;
        if (ir_op == OP_IO_REG) begin
          err_d   = ir_ind;
          state_d = ir_ind ? ST_HALT : ST_REG_EXEC;
        end else if (ir_ind) begin
          state_d = ST_INDIRECT;
        end else begin
          state_d = dispatch_state(ir_op);
        end
      end
      ST_INDIRECT: begin
        o_mem_req  = 1'b1;
        o_addr_sel = 1'b1;
        if (i_mem_ack) begin
          o_ar_load_dr = 1'b1;
          state_d      = dispatch_state(opcode_q);
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_MEM_RD: begin
        o_mem_req  = 1'b1;
        o_addr_sel = 1'b1;
        if (i_mem_ack) begin
          o_dr_load = 1'b1;
          state_d   = (opcode_q == OP_ISZ) ? ST_INC : ST_EXEC;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_EXEC: begin
        o_alu_en = 1'b1;
        case (opcode_q)
          OP_AND:  o_alu_op = ALU_AND;
          OP_ADD:  o_alu_op = ALU_ADD;
          default: o_alu_op = ALU_LDA;
        endcase
        state_d = ST_DONE;
      end
      ST_INC: begin
        o_dr_inc = 1'b1;
        state_d  = ST_MEM_WR;
      end
      ST_MEM_WR: begin
        o_mem_req  = 1'b1;
        o_mem_we   = 1'b1;
        o_addr_sel = 1'b1;
        case (opcode_q)
          OP_BSA:  o_wdata_sel = WSEL_PC;
          OP_ISZ:  o_wdata_sel = WSEL_DR;
          default: o_wdata_sel = WSEL_AC;
        endcase
        if (i_mem_ack) begin
          case (opcode_q)
            OP_BSA: begin
              o_ar_inc = 1'b1;
              state_d  = ST_BRANCH;
            end
            OP_ISZ: begin
              o_pc_inc = i_dr_zero;
              state_d  = ST_DONE;
            end
            default: state_d = ST_DONE;
          endcase
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_BRANCH: begin
        o_pc_load_ar = 1'b1;
        state_d      = ST_DONE;
      end
      ST_REG_EXEC: begin
        o_reg_en = 1'b1;
        o_reg_op = i_ir[11:0];
        o_pc_inc = skip;
        state_d  = i_ir[REG_HLT] ? ST_HALT : ST_DONE;
      end
      ST_DONE: begin
        state_d = i_run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: begin
        o_busy   = 1'b0;
        o_halted = 1'b1;
        o_err    = err_q;
        if (!i_run) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        o_busy  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      opcode_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_seq_control_unit.sv
// tb/tb_seq_control_unit.sv - directed vector bench for seq_control_unit
module tb_seq_control_unit;

  localparam int AWIDTH = 12;
  localparam int DWIDTH = AWIDTH + 4;

  // Expected-output bit positions in the packed compare vector.
  localparam logic [19:0] REQ   = 20'h1 << 19;
  localparam logic [19:0] WE    = 20'h1 << 18;
  localparam logic [19:0] ASEL  = 20'h1 << 17;
  localparam logic [19:0] WS_PC = 20'h1 << 15;
  localparam logic [19:0] WS_DR = 20'h2 << 15;
  localparam logic [19:0] IRL   = 20'h1 << 14;
  localparam logic [19:0] PCI   = 20'h1 << 13;
  localparam logic [19:0] PCL   = 20'h1 << 12;
  localparam logic [19:0] ARIR  = 20'h1 << 11;
  localparam logic [19:0] ARDR  = 20'h1 << 10;
  localparam logic [19:0] ARI   = 20'h1 << 9;
  localparam logic [19:0] DRL   = 20'h1 << 8;
  localparam logic [19:0] DRI   = 20'h1 << 7;
  localparam logic [19:0] OPADD = 20'h1 << 5;
  localparam logic [19:0] OPLDA = 20'h2 << 5;
  localparam logic [19:0] ALUEN = 20'h1 << 4;
  localparam logic [19:0] REGEN = 20'h1 << 3;
  localparam logic [19:0] BUSY  = 20'h1 << 2;
  localparam logic [19:0] HALT  = 20'h1 << 1;
  localparam logic [19:0] ERR   = 20'h1;
  localparam logic [19:0] FET   = REQ | BUSY | IRL | PCI;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              i_run = 1'b0;
  logic [DWIDTH-1:0] i_ir = '0;
  logic              i_mem_ack = 1'b0;
  logic              i_ac_zero = 1'b0, i_ac_neg = 1'b0, i_e = 1'b0, i_dr_zero = 1'b0;
  logic              o_mem_req, o_mem_we, o_addr_sel;
  logic [1:0]        o_wdata_sel, o_alu_op;
  logic              o_ir_load, o_pc_inc, o_pc_load_ar, o_ar_load_ir, o_ar_load_dr;
  logic              o_ar_inc, o_dr_load, o_dr_inc, o_alu_en, o_reg_en;
  logic [11:0]       o_reg_op;
  logic              o_busy, o_halted, o_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_control_unit #(.AWIDTH(AWIDTH), .MEM_TIMEOUT(4), .TO_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_ir(i_ir), .i_mem_ack(i_mem_ack),
    .i_ac_zero(i_ac_zero), .i_ac_neg(i_ac_neg), .i_e(i_e), .i_dr_zero(i_dr_zero),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_addr_sel(o_addr_sel),
    .o_wdata_sel(o_wdata_sel), .o_ir_load(o_ir_load), .o_pc_inc(o_pc_inc),
    .o_pc_load_ar(o_pc_load_ar), .o_ar_load_ir(o_ar_load_ir), .o_ar_load_dr(o_ar_load_dr),
    .o_ar_inc(o_ar_inc), .o_dr_load(o_dr_load), .o_dr_inc(o_dr_inc), .o_alu_op(o_alu_op),
    .o_alu_en(o_alu_en), .o_reg_op(o_reg_op), .o_reg_en(o_reg_en), .o_busy(o_busy),
    .o_halted(o_halted), .o_err(o_err)
  );

  typedef struct {
    logic        run;
    logic [15:0] ir;
    logic        ack;
    logic [3:0]  flg;   // {ac_zero, ac_neg, e, dr_zero}
    logic [19:0] exp;
    logic [11:0] rop;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] actual();
    return {o_reg_op, o_mem_req, o_mem_we, o_addr_sel, o_wdata_sel, o_ir_load, o_pc_inc,
            o_pc_load_ar, o_ar_load_ir, o_ar_load_dr, o_ar_inc, o_dr_load, o_dr_inc,
            o_alu_op, o_alu_en, o_reg_en, o_busy, o_halted, o_err};
  endfunction

  task automatic check(input string name, input logic [19:0] exp, input logic [11:0] rop);
    logic [31:0] got;
    got = actual();
    n_cmp++;
    if (got !== {rop, exp}) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, {rop, exp});
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    i_run = v.run;
    i_ir = v.ir;
    i_mem_ack = v.ack;
    {i_ac_zero, i_ac_neg, i_e, i_dr_zero} = v.flg;
    #1;
    check(v.name, v.exp, v.rop);
  endtask

  function automatic void add(input logic run, input logic [15:0] ir, input logic ack,
                              input logic [3:0] flg, input logic [19:0] exp,
                              input logic [11:0] rop, input string name);
    vec_t v;
    v.run = run; v.ir = ir; v.ack = ack; v.flg = flg; v.exp = exp; v.rop = rop; v.name = name;
    tbl.push_back(v);
  endfunction

  initial begin
    // LDA direct, fetch ack after 3 wait cycles (ack on the timeout cycle wins)
    add(1, 16'h2010, 0, 4'h0, '0, '0, "lda_idle");
    add(1, 16'h2010, 0, 4'h0, REQ | BUSY, '0, "lda_fetch_w1");
    add(1, 16'h2010, 0, 4'h0, REQ | BUSY, '0, "lda_fetch_w2");
    add(1, 16'h2010, 0, 4'h0, REQ | BUSY, '0, "lda_fetch_w3");
    add(1, 16'h2010, 1, 4'h0, FET, '0, "lda_fetch_ack");
    add(1, 16'h2010, 0, 4'h0, BUSY | ARIR, '0, "lda_decode");
    add(1, 16'h2010, 1, 4'h0, REQ | ASEL | BUSY | DRL, '0, "lda_memrd");
    add(1, 16'h2010, 0, 4'h0, BUSY | ALUEN | OPLDA, '0, "lda_exec");
    add(1, 16'h2010, 0, 4'h0, BUSY, '0, "lda_done");
    // Indirect STA
    add(1, 16'hB020, 1, 4'h0, FET, '0, "sta_fetch");
    add(1, 16'hB020, 0, 4'h0, BUSY | ARIR, '0, "sta_decode");
    add(1, 16'hB020, 0, 4'h0, REQ | ASEL | BUSY, '0, "sta_ind_wait");
    add(1, 16'hB020, 1, 4'h0, REQ | ASEL | BUSY | ARDR, '0, "sta_ind_ack");
    add(1, 16'hB020, 1, 4'h0, REQ | WE | ASEL | BUSY, '0, "sta_write");
    add(1, 16'hB020, 0, 4'h0, BUSY, '0, "sta_done");
    // ISZ with skip
    add(1, 16'h6030, 1, 4'h1, FET, '0, "isz1_fetch");
    add(1, 16'h6030, 0, 4'h1, BUSY | ARIR, '0, "isz1_decode");
    add(1, 16'h6030, 1, 4'h1, REQ | ASEL | BUSY | DRL, '0, "isz1_read");
    add(1, 16'h6030, 0, 4'h1, BUSY | DRI, '0, "isz1_inc");
    add(1, 16'h6030, 1, 4'h1, REQ | WE | ASEL | WS_DR | BUSY | PCI, '0, "isz1_write");
    add(1, 16'h6030, 0, 4'h1, BUSY, '0, "isz1_done");
    // ISZ without skip
    add(1, 16'h6030, 1, 4'h0, FET, '0, "isz0_fetch");
    add(1, 16'h6030, 0, 4'h0, BUSY | ARIR, '0, "isz0_decode");
    add(1, 16'h6030, 1, 4'h0, REQ | ASEL | BUSY | DRL, '0, "isz0_read");
    add(1, 16'h6030, 0, 4'h0, BUSY | DRI, '0, "isz0_inc");
    add(1, 16'h6030, 1, 4'h0, REQ | WE | ASEL | WS_DR | BUSY, '0, "isz0_write");
    add(1, 16'h6030, 0, 4'h0, BUSY, '0, "isz0_done");
    // BSA
    add(1, 16'h5040, 1, 4'h0, FET, '0, "bsa_fetch");
    add(1, 16'h5040, 0, 4'h0, BUSY | ARIR, '0, "bsa_decode");
    add(1, 16'h5040, 0, 4'h0, REQ | WE | ASEL | WS_PC | BUSY, '0, "bsa_wr_wait");
    add(1, 16'h5040, 1, 4'h0, REQ | WE | ASEL | WS_PC | BUSY | ARI, '0, "bsa_wr_ack");
    add(1, 16'h5040, 0, 4'h0, BUSY | PCL, '0, "bsa_branch");
    add(1, 16'h5040, 0, 4'h0, BUSY, '0, "bsa_done");
    // Register reference SZA with AC zero -> skip
    add(1, 16'h7004, 1, 4'h8, FET, '0, "sza_fetch");
    add(1, 16'h7004, 0, 4'h8, BUSY | ARIR, '0, "sza_decode");
    add(1, 16'h7004, 0, 4'h8, BUSY | REGEN | PCI, 12'h004, "sza_exec");
    add(1, 16'h7004, 0, 4'h8, BUSY, '0, "sza_done");
    // HLT
    add(1, 16'h7001, 1, 4'h0, FET, '0, "hlt_fetch");
    add(1, 16'h7001, 0, 4'h0, BUSY | ARIR, '0, "hlt_decode");
    add(1, 16'h7001, 0, 4'h0, BUSY | REGEN, 12'h001, "hlt_exec");
    add(1, 16'h7001, 0, 4'h0, HALT, '0, "hlt_hold");
    add(0, 16'h7001, 0, 4'h0, HALT, '0, "hlt_release");
    add(0, 16'h7001, 0, 4'h0, '0, '0, "hlt_idle");
    // I/O instruction -> error halt
    add(1, 16'hF000, 0, 4'h0, '0, '0, "io_idle");
    add(1, 16'hF000, 1, 4'h0, FET, '0, "io_fetch");
    add(1, 16'hF000, 0, 4'h0, BUSY | ARIR, '0, "io_decode");
    add(1, 16'hF000, 0, 4'h0, HALT | ERR, '0, "io_halt");
    add(0, 16'hF000, 0, 4'h0, HALT | ERR, '0, "io_release");
    add(0, 16'hF000, 0, 4'h0, '0, '0, "io_idle_clr");
    // ADD with i_run dropped mid-instruction: completes, then idles
    add(1, 16'h1050, 0, 4'h0, '0, '0, "add_idle");
    add(0, 16'h1050, 1, 4'h0, FET, '0, "add_fetch");
    add(0, 16'h1050, 0, 4'h0, BUSY | ARIR, '0, "add_decode");
    add(0, 16'h1050, 1, 4'h0, REQ | ASEL | BUSY | DRL, '0, "add_read");
    add(0, 16'h1050, 0, 4'h0, BUSY | ALUEN | OPADD, '0, "add_exec");
    add(0, 16'h1050, 0, 4'h0, BUSY, '0, "add_done");
    add(0, 16'h1050, 0, 4'h0, '0, '0, "add_idle2");
    // BUN
    add(1, 16'h4060, 0, 4'h0, '0, '0, "bun_idle");
    add(1, 16'h4060, 1, 4'h0, FET, '0, "bun_fetch");
    add(1, 16'h4060, 0, 4'h0, BUSY | ARIR, '0, "bun_decode");
    add(1, 16'h4060, 0, 4'h0, BUSY | PCL, '0, "bun_branch");
    add(0, 16'h4060, 0, 4'h0, BUSY, '0, "bun_done");
    add(0, 16'h4060, 0, 4'h0, '0, '0, "bun_idle2");

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_hold", '0, '0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset_release", '0, '0);

    foreach (tbl[i]) apply(tbl[i]);

    // Watchdog: no ack for four FETCH cycles
    begin
      vec_t v;
      v.ir = 16'h2010; v.ack = 1'b0; v.flg = 4'h0; v.rop = '0;
      v.run = 1'b1; v.exp = '0;          v.name = "wd_idle";    apply(v);
      for (int k = 0; k < 4; k++) begin
        v.exp = REQ | BUSY; v.name = $sformatf("wd_fetch%0d", k); apply(v);
      end
      v.exp = HALT | ERR; v.name = "wd_halt";    apply(v);
      v.run = 1'b0;       v.name = "wd_release"; apply(v);
      v.run = 1'b1; v.exp = '0;         v.name = "wd_idle2"; apply(v);
      v.exp = REQ | BUSY;               v.name = "rst_fetch"; apply(v);
    end

    // Asynchronous reset in the middle of a fetch
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async", '0, '0);
    @(negedge clk);
    #1;
    check("rst_held", '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
